mips_register_file: RTL and testbench

- 32 x 32-bit MIPS general-purpose register file for the single-cycle datapath.
- Sits directly downstream of the write-register destination mux, which selects rt or rd under regDst. This block consumes that 5-bit write_reg, plus writeback data and regWrite.
- Provides two combinational read ports (rs, rt) to the ALU stage and a debug read port.
- Register $zero is hardwired to 0.

---
 rtl/mips_register_file.sv | 45 ++++
 tb/tb_mips_register_file.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_register_file.sv
// mips_register_file: 32x32 MIPS register file with $zero hardwired, two read ports, a debug port and a commit counter
module mips_register_file #(
    parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC,
    parameter logic [31:0] GP_INIT = 32'h1000_8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic        regWrite,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    input  logic [4:0]  dbg_reg,
    output logic [31:0] dbg_data,
    output logic [31:0] write_count
);
    logic [31:0] regs [0:31];
    logic        commit;

    assign commit = regWrite && (write_reg != 5'd0);

    // storage: entry 0 is only ever cleared, so $zero always reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            regs[28] <= GP_INIT;
            regs[29] <= SP_INIT;
        end else if (commit) begin
            regs[write_reg] <= write_data;
        end
    end

    // count writes that actually landed in a register; wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) write_count <= '0;
        else if (commit) write_count <= write_count + 32'd1;
    end

    // no bypass: write_data feeds back from these reads in the datapath
    assign read_data1 = regs[read_reg1];
    assign read_data2 = regs[read_reg2];
    assign dbg_data   = regs[dbg_reg];
endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: randomized self-checking bench against an array-based register model
module tb_mips_register_file;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [4:0]  read_reg1 = 0, read_reg2 = 0, write_reg = 0, dbg_reg = 0;
    logic [31:0] write_data = 0;
    logic        regWrite = 0;
    logic [31:0] read_data1, read_data2, dbg_data, write_count;

    int passed = 0;
    int total = 0;
    logic [31:0] m [32];
    logic [31:0] cnt;

    mips_register_file dut (
        .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .regWrite(regWrite),
        .read_data1(read_data1), .read_data2(read_data2), .dbg_reg(dbg_reg),
        .dbg_data(dbg_data), .write_count(write_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        m[28] = 32'h1000_8000;
        m[29] = 32'h7FFF_EFFC;
        cnt = 0;
    endtask

    task automatic model_write(input logic we, input logic [4:0] wr, input logic [31:0] wd);
        if (we && wr != 0) begin
            m[wr] = wd;
            cnt = cnt + 1;
        end
    endtask

    task automatic do_write(input logic [4:0] wr, input logic [31:0] wd);
        regWrite = 1; write_reg = wr; write_data = wd;
        tick();
        model_write(1'b1, wr, wd);
        regWrite = 0;
    endtask

    task automatic test_reset();
        model_reset();
        #3 rst_n = 1;
        tick();
        do_write(5'd3, $urandom | 32'h1);
        do_write(5'd28, 32'h0BAD_F00D);
        do_write(5'd31, $urandom | 32'h1);
        #2 rst_n = 0;
        #1;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            dbg_reg = 5'(i); read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
            #1;
            total++;
            if (dbg_data !== m[i]) $display("FAIL reset_dbg[%0d] got %h exp %h", i, dbg_data, m[i]); else passed++;
            total++;
            if (read_data1 !== m[i]) $display("FAIL reset_rd1[%0d] got %h exp %h", i, read_data1, m[i]); else passed++;
            total++;
            if (read_data2 !== m[31 - i]) $display("FAIL reset_rd2[%0d] got %h exp %h", 31 - i, read_data2, m[31 - i]); else passed++;
        end
        total++;
        if (write_count !== cnt) $display("FAIL reset_count got %0d exp %0d", write_count, cnt); else passed++;
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_basic();
        regWrite = 1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF; read_reg1 = 5'd5;
        #1;
        total++;
        if (read_data1 !== m[5]) $display("FAIL no_bypass got %h exp %h", read_data1, m[5]); else passed++;
        tick();
        model_write(1'b1, 5'd5, 32'hDEAD_BEEF);
        regWrite = 0;
        #1;
        total++;
        if (read_data1 !== m[5]) $display("FAIL basic_read got %h exp %h", read_data1, m[5]); else passed++;
        total++;
        if (write_count !== cnt) $display("FAIL basic_count got %0d exp %0d", write_count, cnt); else passed++;
    endtask

    task automatic test_zero();
        do_write(5'd0, 32'hFFFF_FFFF);
        read_reg2 = 5'd0;
        #1;
        total++;
        if (read_data2 !== m[0]) $display("FAIL zero_read got %h exp %h", read_data2, m[0]); else passed++;
        total++;
        if (write_count !== cnt) $display("FAIL zero_count got %0d exp %0d", write_count, cnt); else passed++;
    endtask

    task automatic test_disabled();
        regWrite = 0; write_reg = 5'd7; write_data = 32'h1234_5678;
        repeat (3) tick();
        dbg_reg = 5'd7;
        #1;
        total++;
        if (dbg_data !== m[7]) $display("FAIL disabled_read got %h exp %h", dbg_data, m[7]); else passed++;
        total++;
        if (write_count !== cnt) $display("FAIL disabled_count got %0d exp %0d", write_count, cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        do_write(5'd10, 32'hA5A5_A5A5);
        regWrite = 1; write_reg = 5'd11; write_data = 32'h1;
        #3 rst_n = 0;
        model_reset();
        tick();
        regWrite = 0;
        read_reg1 = 5'd10; read_reg2 = 5'd11;
        #1;
        total++;
        if (read_data1 !== m[10]) $display("FAIL midrst_r10 got %h exp %h", read_data1, m[10]); else passed++;
        total++;
        if (read_data2 !== m[11]) $display("FAIL midrst_r11 got %h exp %h", read_data2, m[11]); else passed++;
        total++;
        if (write_count !== cnt) $display("FAIL midrst_count got %0d exp %0d", write_count, cnt); else passed++;
        rst_n = 1;
        do_write(5'd11, 32'h2);
        #1;
        total++;
        if (read_data2 !== m[11]) $display("FAIL postrst_r11 got %h exp %h", read_data2, m[11]); else passed++;
        total++;
        if (write_count !== cnt) $display("FAIL postrst_count got %0d exp %0d", write_count, cnt); else passed++;
    endtask

    task automatic test_sweep();
        #2 rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        tick();
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h0101_0101);
        for (int i = 0; i < 32; i++) begin
            dbg_reg = 5'(i); read_reg1 = 5'(i); read_reg2 = 5'((i + 7) % 32);
            #1;
            total++;
            if (dbg_data !== m[i]) $display("FAIL sweep_dbg[%0d] got %h exp %h", i, dbg_data, m[i]); else passed++;
            total++;
            if (read_data1 !== m[i]) $display("FAIL sweep_rd1[%0d] got %h exp %h", i, read_data1, m[i]); else passed++;
            total++;
            if (read_data2 !== m[(i + 7) % 32]) $display("FAIL sweep_rd2[%0d] got %h exp %h", (i + 7) % 32, read_data2, m[(i + 7) % 32]); else passed++;
        end
        total++;
        if (write_count !== cnt) $display("FAIL sweep_count got %0d exp %0d", write_count, cnt); else passed++;
    endtask

    task automatic test_random();
        logic        we;
        logic [4:0]  wr, r1, r2, dr;
        logic [31:0] wd;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            wr = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = (n % 5 == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = (n % 7 == 0) ? r1 : 5'($urandom_range(0, 31));
            dr = (n % 7 == 0) ? r1 : 5'($urandom_range(0, 31));
            regWrite = we; write_reg = wr; write_data = wd;
            read_reg1 = r1; read_reg2 = r2; dbg_reg = dr;
            #1;
            total++;
            if (read_data1 !== m[r1]) $display("FAIL rand_rd1[%0d] got %h exp %h", r1, read_data1, m[r1]); else passed++;
            total++;
            if (read_data2 !== m[r2]) $display("FAIL rand_rd2[%0d] got %h exp %h", r2, read_data2, m[r2]); else passed++;
            total++;
            if (dbg_data !== m[dr]) $display("FAIL rand_dbg[%0d] got %h exp %h", dr, dbg_data, m[dr]); else passed++;
            tick();
            model_write(we, wr, wd);
            total++;
            if (write_count !== cnt) $display("FAIL rand_count got %0d exp %0d", write_count, cnt); else passed++;
        end
        regWrite = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_disabled();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
